fdiv_iter: RTL and testbench
============================

# fdiv_iter

Iterative IEEE-754 single-precision divider that consumes the square-root result produced by `FSqrt` and divides a numerator by it, for example for vector normalisation (x / sqrt(s)). It accepts one operand pair through a valid/ready handshake and runs a radix-2 restoring divide over a fixed number of cycles. It then rounds, packs and holds the result until the consumer takes it. Denormals are flushed to zero, matching the surrounding datapath.

## Interface
- `ITER_PER_CYCLE`, default 1: quotient bits produced per DIV cycle; only 1 or 2 are legal.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `num`  in  32  numerator, IEEE-754 single.
- `den`  in  32  denominator, IEEE-754 single (the `FSqrt` `out`).
- `out_valid`  out  1  result held on `quo`.
- `out_ready`  in  1  consumer takes the result.
- `quo`  out  32  quotient, IEEE-754 single.

## Operation
- FSM states, in order: IDLE, UNPACK, DIV, NORM, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, register `num` and `den`, then go to UNPACK.
- UNPACK (1 cycle):
  - Split sign, exponent and mantissa; exponent 0 is treated as zero (FTZ).
  - Restore the hidden 1.
  - Classify each operand as ZERO, NORM, INF or NAN.
  - Compute sign = sa^sb and e = ea − eb + 127 as a signed 10-bit value.
- DIV (N = ceil(26/ITER_PER_CYCLE) cycles):
  - Restoring divide of 24-bit mantissas, producing 26 quotient bits: 24 significand, plus guard and round.
  - sticky = (final remainder ≠ 0).
  - A cycle counter counts down from N−1; leave DIV when it reaches 0.
  - DIV runs even for special operands, so latency is fixed.
- NORM (1 cycle):
  - If the quotient MSB is 0, shift left by 1 and set e−1.
  - Round to nearest even. A mantissa carry-out gives e+1.
  - Apply special cases, in this priority:
    - Either operand NAN, or 0/0, or INF/INF → 0x7FC00000.
    - x/0 with x ≠ 0, or INF/x → {sign, 0xFF, 0}.
    - 0/x, or x/INF → {sign, 0x00, 0}.
    - Final e ≥ 255 → signed infinity.
    - Final e ≤ 0 → signed zero (FTZ, no denormal output).
- DONE: `out_valid`=1 and `quo` held stable. On `out_ready`, go to IDLE on the next edge.
- Reset (`rst_n`=0 at any edge, in any state):
  - State → IDLE, `out_valid`=0, `quo`=0, counter=0.
  - An in-flight operation is discarded and no output is produced.
  - While `rst_n` is low, `in_ready` follows the state, so it is 1 from the first edge after reset.
- `in_valid` is ignored outside IDLE. The consumer must not see `in_ready` and `out_valid` both high in the same cycle.

## Timing
- Take the accept edge as edge k. Then:
  - Cycle k+1 is UNPACK.
  - Cycles k+2 … k+1+N are DIV.
  - Cycle k+2+N is NORM.
  - `out_valid` rises after edge k+3+N.
- ITER_PER_CYCLE=1: N=26, so `out_valid` is high 29 cycles after acceptance. ITER_PER_CYCLE=2: N=13, so 16 cycles.
- If `out_ready` is high when `out_valid` rises, DONE lasts exactly 1 cycle. `in_ready` is high 1 cycle later.
- Minimum issue interval: N+4 cycles.
- `quo` changes only on the edge entering DONE or on reset.

## Configuration
- `FDIV_ROUND_EN` defined: round to nearest even using guard, round and sticky, as above.
- `FDIV_ROUND_EN` undefined: truncate. Guard, round and sticky are discarded, there is no rounding increment and no carry-out path.
- Latency is identical either way.

## Structure
- Shared package `fpu_pkg` holds:
  - Field widths: `EXP_W`=8, `MAN_W`=23, `BIAS`=127.
  - Constants `QNAN`=32'h7FC00000 and `POS_INF`=32'h7F800000.
  - Class enum {ZERO, NORM, INF, NAN}.
  - FSM state enum.
- One sub-module, `fp_round_pack`. It is purely combinational: inputs are sign, signed exponent, 26-bit quotient and sticky; output is the packed 32-bit word. It covers normalise, round, and the overflow/underflow clamps, and is reusable by the neighbouring FP blocks.

## Test plan
- 0x40C00000 / 0x40400000 (6.0/3.0) → `quo`=0x40000000. `out_valid` is high exactly 29 cycles after acceptance (ITER_PER_CYCLE=1), or 16 cycles with ITER_PER_CYCLE=2.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB with `FDIV_ROUND_EN`, 0x3EAAAAAA without it. Also 0x3F800000 / 0x40000000 → 0x3F000000.
- Special cases:
  - 0xBF800000 / 0x00000000 → 0xFF800000.
  - 0x00000000 / 0x00000000 → 0x7FC00000.
  - 0x00700000 (denormal) / 0x3F800000 → 0x00000000.
  - 0x7F000000 / 0x00800000 → 0x7F800000 (overflow).
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE. `quo` and `out_valid` stay stable and `in_ready` stays 0. Raise `out_ready` → IDLE next cycle.
- Reset mid-DIV: pulse `rst_n`=0 for 1 cycle at DIV cycle 5. Afterwards `out_valid`=0 and `in_ready`=1. A new pair 0x41D26666 / 0x40000000 gives 0x41526666.
- Back-to-back: issue 10 pairs with `out_ready` tied to 1. Each is accepted N+4 cycles after the previous one, and all results match the reference model.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared single-precision field widths, constants, classes and divider FSM states
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_DIV,
        ST_NORM,
        ST_DONE
    } fdiv_state_e;

    // Exponent 0 always classifies as zero: denormal inputs are flushed.
    function automatic fp_class_e fp_classify(input logic [31:0] x);
        if (x[30:23] == '0)
            return CLS_ZERO;
        if (x[30:23] == '1)
            return (x[22:0] == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

    function automatic logic [MAN_W:0] fp_mantissa(input logic [31:0] x);
        return (x[30:23] == '0) ? '0 : {1'b1, x[MAN_W-1:0]};
    endfunction

endpackage

// File: rtl/fdiv_iter_if.sv
// rtl/fdiv_iter_if.sv - operand/result handshake bundle for fdiv_iter
interface fdiv_iter_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] num;
    logic [31:0] den;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quo;

    modport master (
        output in_valid, num, den, out_ready,
        input  in_ready, out_valid, quo
    );

    modport slave (
        input  in_valid, num, den, out_ready,
        output in_ready, out_valid, quo
    );

endinterface

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - normalise, round and pack a 26-bit quotient into an IEEE-754 single
// Rounding to nearest even only when FDIV_ROUND_EN is defined; otherwise truncates.
module fp_round_pack
    import fpu_pkg::*;
(
    input  logic              sign_i,
    input  logic signed [9:0] exp_i,
    input  logic [25:0]       quot_i,
    input  logic              sticky_i,
    output logic [31:0]       word_o
);

    logic [25:0]       q_n;
    logic signed [9:0] e_n;
    logic [24:0]       sig_r;
    logic              unused_w;

`ifdef FDIV_ROUND_EN
    assign unused_w = sig_r[23];
`else
    assign unused_w = ^{sig_r[24:23], q_n[1:0], sticky_i};
`endif

    always_comb begin
        q_n = quot_i;
        e_n = exp_i;
        if (!quot_i[25]) begin
            q_n = {quot_i[24:0], 1'b0};
            e_n = exp_i - 10'sd1;
        end
`ifdef FDIV_ROUND_EN
        // q_n[0] after a shift is unknown, but round|sticky is exactly "remainder nonzero"
        sig_r = {1'b0, q_n[25:2]} + 25'(q_n[1] & (q_n[0] | sticky_i | q_n[2]));
        if (sig_r[24])
            e_n = e_n + 10'sd1;
`else
        sig_r = {1'b0, q_n[25:2]};
`endif
        if (e_n >= 10'sd255)
            word_o = {sign_i, POS_INF[30:0]};
        else if (e_n <= 10'sd0)
            word_o = {sign_i, 31'd0};
        else
            word_o = {sign_i, e_n[EXP_W-1:0], sig_r[MAN_W-1:0]};
    end

endmodule

// File: rtl/fdiv_iter.sv
// rtl/fdiv_iter.sv - fixed-latency radix-2 restoring single-precision divider (num / den)
// FDIV_ROUND_EN selects round-to-nearest-even in fp_round_pack; latency is unaffected.
module fdiv_iter
    import fpu_pkg::*;
#(
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    fdiv_iter_if.slave bus
);

    localparam int         N_DIV    = (26 + ITER_PER_CYCLE - 1) / ITER_PER_CYCLE;
    localparam logic [4:0] CNT_INIT = 5'(N_DIV - 1);

    fdiv_state_e       state_q, state_d;
    fp_class_e         cls_a_q, cls_a_d, cls_b_q, cls_b_d;
    logic [31:0]       num_q, num_d, den_q, den_d, quo_q, quo_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [24:0]       rem_q, rem_d;
    logic [23:0]       dsr_q, dsr_d;
    logic [25:0]       quot_q, quot_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       packed_w, result_w;

    fp_round_pack u_round_pack (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .quot_i   (quot_q),
        .sticky_i (rem_q != '0),
        .word_o   (packed_w)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
        end
    end

    // Working registers are always overwritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        num_q   <= num_d;
        den_q   <= den_d;
        cls_a_q <= cls_a_d;
        cls_b_q <= cls_b_d;
        sign_q  <= sign_d;
        exp_q   <= exp_d;
        rem_q   <= rem_d;
        dsr_q   <= dsr_d;
        quot_q  <= quot_d;
    end

    always_comb begin
        result_w = packed_w;
        if (cls_a_q == CLS_NAN || cls_b_q == CLS_NAN ||
            (cls_a_q == CLS_ZERO && cls_b_q == CLS_ZERO) ||
            (cls_a_q == CLS_INF && cls_b_q == CLS_INF))
            result_w = QNAN;
        else if (cls_b_q == CLS_ZERO || cls_a_q == CLS_INF)
            result_w = {sign_q, POS_INF[30:0]};
        else if (cls_a_q == CLS_ZERO || cls_b_q == CLS_INF)
            result_w = {sign_q, 31'd0};
    end

    assign bus.quo = quo_q;

    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        den_d         = den_q;
        cls_a_d       = cls_a_q;
        cls_b_d       = cls_b_q;
        sign_d        = sign_q;
        exp_d         = exp_q;
        rem_d         = rem_q;
        dsr_d         = dsr_q;
        quot_d        = quot_q;
        cnt_d         = cnt_q;
        quo_d         = quo_q;
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    num_d   = bus.num;
                    den_d   = bus.den;
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                cls_a_d = fp_classify(num_q);
                cls_b_d = fp_classify(den_q);
                sign_d  = num_q[31] ^ den_q[31];
                exp_d   = $signed({2'b00, num_q[30:23]}) - $signed({2'b00, den_q[30:23]})
                          + 10'(BIAS);
                rem_d   = {1'b0, fp_mantissa(num_q)};
                dsr_d   = fp_mantissa(den_q);
                quot_d  = '0;
                cnt_d   = CNT_INIT;
                state_d = ST_DIV;
            end
            ST_DIV: begin
                // Partial remainder stays below 2*divisor, so 25 bits never overflow.
                for (int i = 0; i < ITER_PER_CYCLE; i++) begin
                    quot_d = {quot_d[24:0], rem_d >= {1'b0, dsr_q}};
                    if (rem_d >= {1'b0, dsr_q})
                        rem_d = rem_d - {1'b0, dsr_q};
                    rem_d = {rem_d[23:0], 1'b0};
                end
                if (cnt_q == '0)
                    state_d = ST_NORM;
                else
                    cnt_d = cnt_q - 5'd1;
            end
            ST_NORM: begin
                quo_d   = result_w;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fdiv_iter.sv
// tb/tb_fdiv_iter.sv - self-checking bench for fdiv_iter; honours FDIV_ROUND_EN like the RTL
module tb_fdiv_iter;

    localparam int ITER_PER_CYCLE = 1;
    localparam int N_DIV = (26 + ITER_PER_CYCLE - 1) / ITER_PER_CYCLE;
    localparam int LAT   = N_DIV + 3;
    localparam int GAP   = N_DIV + 4;
`ifdef FDIV_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] exp_q[$];
    int          acc_q[$];
    bit          prev_ov = 1'b0;

    logic [31:0] va [10] = '{32'h40490FDB, 32'h3F800000, 32'hC1200000, 32'h7F7FFFFF, 32'h00800000,
                             32'h7FC00001, 32'h7F800000, 32'h42F60000, 32'h3FFFFFFF, 32'h3DCCCCCD};
    logic [31:0] vb [10] = '{32'h3FB504F3, 32'h40400000, 32'h40A00000, 32'h3F000000, 32'h7F000000,
                             32'h3F800000, 32'h7F800000, 32'h7F800000, 32'h3F800001, 32'h3F3504F3};

    fdiv_iter_if bus ();

    fdiv_iter #(.ITER_PER_CYCLE(ITER_PER_CYCLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // Exact quotient from wide integer division, then IEEE rounding of the 24-bit significand.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e, sh;
        longint unsigned ma, mb, q, r, sig, low, half;
        bit s, za, zb, ia, ib, na, nb;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        ib = (eb == 255) && (b[22:0] == 0);
        nb = (eb == 255) && (b[22:0] != 0);
        if (na || nb || (za && zb) || (ia && ib)) return 32'h7FC00000;
        if (zb || ia) return {s, 8'hFF, 23'd0};
        if (za || ib) return {s, 31'd0};
        ma = {40'd0, 1'b1, a[22:0]};
        mb = {40'd0, 1'b1, b[22:0]};
        q  = (ma << 30) / mb;
        r  = (ma << 30) % mb;
        e  = ea - eb + 127;
        if (q >= (64'd1 << 30)) sh = 7;
        else begin
            sh = 6;
            e  = e - 1;
        end
        sig  = q >> sh;
        low  = q & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        if (ROUND && ((low > half) || (low == half && (r != 0 || sig[0])))) begin
            sig = sig + 1;
            if (sig == (64'd1 << 24)) begin
                sig = 64'd1 << 23;
                e   = e + 1;
            end
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], sig[22:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, output int acc);
        int t = 0;
        while (!bus.in_ready && t < 200) begin
            step();
            t++;
        end
        chk("send_in_ready", {31'd0, bus.in_ready}, 32'd1);
        acc          = cyc;
        bus.in_valid = 1'b1;
        bus.num      = a;
        bus.den      = b;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int t);
        t = 0;
        while (!bus.out_valid && t < 200) begin
            step();
            t++;
        end
    endtask

    task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit);
        int acc, t;
        send(a, b, acc);
        wait_out(t);
        chk({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk(name, bus.quo, lit);
        step();
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_valid_overlap", {31'd0, bus.in_ready & bus.out_valid}, 32'd0);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_out_valid: got quo %h with nothing outstanding, expected none", bus.quo);
                end else begin
                    chk("model_quo", bus.quo, exp_q[0]);
                    if (!prev_ov) chk("latency", 32'(cyc - acc_q[0]), 32'(LAT));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_div(bus.num, bus.den));
                acc_q.push_back(cyc);
            end
            prev_ov = bus.out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    initial begin
        int t, acc, prev_acc, hi;
        bus.in_valid  = 1'b0;
        bus.num       = '0;
        bus.den       = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        step();
        step();
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_quo", bus.quo, 32'd0);
        rst_n = 1'b1;
        step();

        chk("model_6_3", ref_div(32'h40C00000, 32'h40400000), 32'h40000000);
        chk("model_1_3", ref_div(32'h3F800000, 32'h40400000), ROUND ? 32'h3EAAAAAB : 32'h3EAAAAAA);
        chk("model_ovf", ref_div(32'h7F000000, 32'h00800000), 32'h7F800000);
        chk("model_neg_div", ref_div(32'hC1200000, 32'h40A00000), 32'hC0000000);

        send(32'h40C00000, 32'h40400000, acc);
        wait_out(t);
        chk("lat_6_3", 32'(t + 1), (ITER_PER_CYCLE == 1) ? 32'd29 : 32'd16);
        chk("quo_6_3", bus.quo, 32'h40000000);
        step();

        run("quo_1_3", 32'h3F800000, 32'h40400000, ROUND ? 32'h3EAAAAAB : 32'h3EAAAAAA);
        run("quo_1_2", 32'h3F800000, 32'h40000000, 32'h3F000000);
        run("neg_div0", 32'hBF800000, 32'h00000000, 32'hFF800000);
        run("zero_zero", 32'h00000000, 32'h00000000, 32'h7FC00000);
        run("denorm_ftz", 32'h00700000, 32'h3F800000, 32'h00000000);
        run("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000);

        bus.out_ready = 1'b0;
        send(32'h40C00000, 32'h40400000, acc);
        wait_out(t);
        hi = 0;
        repeat (10) begin
            if (bus.out_valid && !bus.in_ready && bus.quo == 32'h40000000) hi++;
            step();
        end
        chk("bp_hold_cycles", 32'(hi), 32'd10);
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);

        send(32'h40C00000, 32'h40400000, acc);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        hi = 0;
        repeat (40) begin
            step();
            if (bus.out_valid) hi++;
        end
        chk("rst_no_output", 32'(hi), 32'd0);
        run("rst_recover", 32'h41D26666, 32'h40000000, 32'h41526666);

        prev_acc = 0;
        for (int i = 0; i < 10; i++) begin
            send(va[i], vb[i], acc);
            if (i > 0) chk("b2b_gap", 32'(acc - prev_acc), 32'(GAP));
            prev_acc = acc;
        end
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            step();
            t++;
        end
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
